fpu_postproc_arb: RTL and testbench

//  Arbitrates the shared FP post-processing datapath (normalize shift, shift/LZA correction, rounding)

---
 rtl/fpu_postproc_arb.sv | 122 ++++++++++++
 tb/tb_fpu_postproc_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_postproc_arb.sv
// Arbiter for the shared FP post-processing datapath: FMA vs divsqrt, with a one-entry
// divsqrt result buffer, a registered issue stage and a starvation guard for FMA.
module fpu_postproc_arb #(
    parameter int unsigned PW     = 128,
    parameter int unsigned TAGW   = 5,
    parameter int unsigned STARVE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FlushE,
    input  logic            FmaValid,
    output logic            FmaReady,
    input  logic [PW-1:0]   FmaPayload,
    input  logic [TAGW-1:0] FmaTag,
    input  logic            DivValid,
    output logic            DivReady,
    input  logic [PW-1:0]   DivPayload,
    input  logic [TAGW-1:0] DivTag,
    output logic            PostValid,
    input  logic            PostReady,
    output logic [PW-1:0]   PostPayload,
    output logic [TAGW-1:0] PostTag,
    output logic            PostFmaOp,
    output logic            PostDivOp,
    output logic            DivBufFull
);

    localparam int unsigned CW = $clog2(STARVE + 1);

    typedef enum logic {DIVPRI = 1'b0, FMAPRI = 1'b1} arbState_t;

    arbState_t       state, stateNext;
    logic [CW-1:0]   starveCnt, starveCntNext;
    logic [PW-1:0]   bufPayload;
    logic [TAGW-1:0] bufTag;
    logic            load, divWin, fmaHs, divHs;

    assign load     = ~PostValid | PostReady;
    assign DivReady = ~DivBufFull & ~FlushE;
    assign FmaReady = load & ~FlushE & ~((state == DIVPRI) & DivBufFull);
    assign divWin   = load & DivBufFull & ~FlushE & ((state == DIVPRI) | ~FmaValid);
    assign fmaHs    = FmaValid & FmaReady;
    assign divHs    = DivValid & DivReady;

    // Priority state and starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DIVPRI;
            starveCnt <= '0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveCntNext;
        end
    end

    always_comb begin
        stateNext     = state;
        starveCntNext = starveCnt;
        if (FlushE) begin
            stateNext     = DIVPRI;
            starveCntNext = '0;
        end else if (fmaHs) begin
            starveCntNext = '0;
            if (state == FMAPRI) stateNext = DIVPRI;
        end else begin
            // FMA lost a Load to the divsqrt buffer; only reachable in DIVPRI
            if (FmaValid & divWin) begin
                if (starveCnt == CW'(STARVE - 1)) begin
                    starveCntNext = '0;
                    stateNext     = FMAPRI;
                end else begin
                    starveCntNext = starveCnt + CW'(1);
                end
            end
            if ((state == FMAPRI) & ~FmaValid) stateNext = DIVPRI;
        end
    end

    // One-entry divsqrt result buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            DivBufFull <= 1'b0;
            bufPayload <= '0;
            bufTag     <= '0;
        end else if (FlushE) begin
            DivBufFull <= 1'b0;
        end else if (divHs) begin
            DivBufFull <= 1'b1;
            bufPayload <= DivPayload;
            bufTag     <= DivTag;
        end else if (divWin) begin
            DivBufFull <= 1'b0;
        end
    end

    // Issue register toward post-processing; payload/tag hold when nothing wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PostValid   <= 1'b0;
            PostPayload <= '0;
            PostTag     <= '0;
            PostFmaOp   <= 1'b0;
            PostDivOp   <= 1'b0;
        end else if (FlushE) begin
            PostValid <= 1'b0;
            PostFmaOp <= 1'b0;
            PostDivOp <= 1'b0;
        end else if (load) begin
            PostValid <= fmaHs | divWin;
            PostFmaOp <= fmaHs;
            PostDivOp <= divWin;
            if (fmaHs) begin
                PostPayload <= FmaPayload;
                PostTag     <= FmaTag;
            end else if (divWin) begin
                PostPayload <= bufPayload;
                PostTag     <= bufTag;
            end
        end
    end

endmodule

// File: tb/tb_fpu_postproc_arb.sv
// Randomized and directed bench for fpu_postproc_arb against a transaction-level model.
module tb_fpu_postproc_arb;

    localparam int unsigned PW     = 128;
    localparam int unsigned TAGW   = 5;
    localparam int unsigned STARVE = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            FlushE;
    logic            FmaValid;
    logic            FmaReady;
    logic [PW-1:0]   FmaPayload;
    logic [TAGW-1:0] FmaTag;
    logic            DivValid;
    logic            DivReady;
    logic [PW-1:0]   DivPayload;
    logic [TAGW-1:0] DivTag;
    logic            PostValid;
    logic            PostReady;
    logic [PW-1:0]   PostPayload;
    logic [TAGW-1:0] PostTag;
    logic            PostFmaOp;
    logic            PostDivOp;
    logic            DivBufFull;

    int errCnt   = 0;
    int checkCnt = 0;

    fpu_postproc_arb #(.PW(PW), .TAGW(TAGW), .STARVE(STARVE)) dut (
        .clk(clk), .reset(reset), .FlushE(FlushE),
        .FmaValid(FmaValid), .FmaReady(FmaReady), .FmaPayload(FmaPayload), .FmaTag(FmaTag),
        .DivValid(DivValid), .DivReady(DivReady), .DivPayload(DivPayload), .DivTag(DivTag),
        .PostValid(PostValid), .PostReady(PostReady), .PostPayload(PostPayload), .PostTag(PostTag),
        .PostFmaOp(PostFmaOp), .PostDivOp(PostDivOp), .DivBufFull(DivBufFull)
    );

    always #5 clk = ~clk;

    // Model: issue register contents, divsqrt buffer, FMA loss count and priority flag
    bit              mValid, mFmaOp, mDivOp, mBufFull, mFmaPri;
    logic [PW-1:0]   mPayload, mBufPay;
    logic [TAGW-1:0] mTag, mBufTag;
    int              mLosses;
    int              waitLoads;
    int              divRun, maxDivRun;

    task automatic checkVal(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mValid = 0; mFmaOp = 0; mDivOp = 0; mBufFull = 0; mFmaPri = 0;
        mPayload = '0; mTag = '0; mBufPay = '0; mBufTag = '0;
        mLosses = 0; waitLoads = 0; divRun = 0;
    endtask

    task automatic checkRegs();
        checkVal("postValid", PW'(PostValid), PW'(mValid));
        checkVal("postPayload", PostPayload, mPayload);
        checkVal("postTag", PW'(PostTag), PW'(mTag));
        checkVal("postFmaOp", PW'(PostFmaOp), PW'(mFmaOp));
        checkVal("postDivOp", PW'(PostDivOp), PW'(mDivOp));
        checkVal("divBufFull", PW'(DivBufFull), PW'(mBufFull));
    endtask

    // One clock: drive inputs, check ready outputs mid-cycle, advance model, check registers
    task automatic step(input bit fv, input logic [PW-1:0] fp, input logic [TAGW-1:0] ft,
                        input bit dv, input logic [PW-1:0] dp, input logic [TAGW-1:0] dt,
                        input bit pr, input bit fl);
        bit canLoad, expFmaRdy, expDivRdy, fmaAcc, divAcc, divIssue;
        FmaValid = fv; FmaPayload = fp; FmaTag = ft;
        DivValid = dv; DivPayload = dp; DivTag = dt;
        PostReady = pr; FlushE = fl;
        #4;
        canLoad   = !mValid || pr;
        expDivRdy = !mBufFull && !fl;
        // A full buffer blocks FMA unless FMA currently holds priority
        expFmaRdy = canLoad && !fl && !(mBufFull && !mFmaPri);
        checkVal("fmaReady", PW'(FmaReady), PW'(expFmaRdy));
        checkVal("divReady", PW'(DivReady), PW'(expDivRdy));
        fmaAcc   = fv && expFmaRdy;
        divAcc   = dv && expDivRdy;
        divIssue = canLoad && !fl && mBufFull && !fmaAcc;
        if (fl || !fv) waitLoads = 0;
        else if (fv && FmaReady) begin
            checkVal("starveBound", PW'(waitLoads <= int'(STARVE)), PW'(1));
            waitLoads = 0;
        end else if (canLoad) waitLoads++;
        @(posedge clk);
        if (fl) begin
            mValid = 0; mFmaOp = 0; mDivOp = 0; mBufFull = 0; mFmaPri = 0; mLosses = 0;
        end else begin
            if (canLoad) begin
                mValid = fmaAcc || divIssue;
                mFmaOp = fmaAcc;
                mDivOp = divIssue;
                if (fmaAcc) begin mPayload = fp; mTag = ft; end
                else if (divIssue) begin mPayload = mBufPay; mTag = mBufTag; end
            end
            if (divAcc) begin mBufFull = 1; mBufPay = dp; mBufTag = dt; end
            else if (divIssue) mBufFull = 0;
            if (fmaAcc) begin
                mLosses = 0;
                mFmaPri = 0;
            end else begin
                if (divIssue && fv) begin
                    mLosses++;
                    if (mLosses == int'(STARVE)) begin mLosses = 0; mFmaPri = 1; end
                end
                if (!fv) mFmaPri = 0;
            end
        end
        #1;
        checkRegs();
        if (canLoad && PostValid && PostDivOp && fv) begin
            divRun++;
            if (divRun > maxDivRun) maxDivRun = divRun;
        end else if (canLoad && PostValid && PostFmaOp) divRun = 0;
        if (PostFmaOp && PostDivOp) checkVal("opOneHot", PW'({PostFmaOp, PostDivOp}), PW'(0));
    endtask

    task automatic idle(input bit pr);
        step(0, '0, '0, 0, '0, '0, pr, 0);
    endtask

    function automatic logic [PW-1:0] rndPay();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset = 1; FlushE = 0; FmaValid = 0; FmaPayload = '0; FmaTag = '0;
        DivValid = 0; DivPayload = '0; DivTag = '0; PostReady = 0;
        modelReset();
        maxDivRun = 0;
        #12;
        checkRegs();
        checkVal("rstDivReady", PW'(DivReady), PW'(1));
        checkVal("rstFmaReady", PW'(FmaReady), PW'(1));
        reset = 0;
        @(posedge clk); #1;

        // FMA single issue
        step(1, PW'(128'h5A), 5'd3, 0, '0, '0, 1, 0);
        checkVal("t1Payload", PostPayload, PW'(128'h5A));
        checkVal("t1Tag", PW'(PostTag), PW'(3));
        checkVal("t1FmaOp", PW'(PostFmaOp), PW'(1));

        // divsqrt alone: two-cycle latency through the buffer
        step(0, '0, '0, 1, PW'(128'hD1), 5'd7, 1, 0);
        checkVal("t2BufFull", PW'(DivBufFull), PW'(1));
        checkVal("t2NoIssueYet", PW'(PostValid), PW'(0));
        idle(1);
        checkVal("t2DivOp", PW'(PostDivOp), PW'(1));
        checkVal("t2Tag", PW'(PostTag), PW'(7));
        checkVal("t2BufEmpty", PW'(DivBufFull), PW'(0));

        // Hold under backpressure
        step(1, PW'(128'h11), 5'd1, 0, '0, '0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, PW'(128'h22), 5'd2, 0, '0, '0, 0, 0);
        checkVal("t3Held", PostPayload, PW'(128'h11));
        step(1, PW'(128'h22), 5'd2, 0, '0, '0, 1, 0);
        checkVal("t3NextFma", PostPayload, PW'(128'h22));
        idle(1);

        // Starvation: div refills during every stalled cycle, FMA always valid
        maxDivRun = 0; divRun = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) step(1, rndPay(), 5'(i), 1, rndPay(), 5'(i + 1), 0, 0);
            else            step(1, rndPay(), 5'(i), 0, '0, '0, 1, 0);
        end
        checkVal("t4MaxDivRun", PW'(maxDivRun), PW'(STARVE));
        idle(1); idle(1); idle(1);

        // Flush with a valid issue and a full buffer
        step(1, PW'(128'hAA), 5'd4, 1, PW'(128'hBB), 5'd5, 1, 0);
        checkVal("t5PreValid", PW'(PostValid), PW'(1));
        checkVal("t5PreFull", PW'(DivBufFull), PW'(1));
        step(1, rndPay(), 5'd6, 1, rndPay(), 5'd6, 0, 1);
        checkVal("t5Valid", PW'(PostValid), PW'(0));
        checkVal("t5Full", PW'(DivBufFull), PW'(0));
        idle(0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), rndPay(), 5'($urandom),
                 ($urandom_range(0, 9) < 4), rndPay(), 5'($urandom),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end

        // Async reset mid-hold
        step(1, PW'(128'hCC), 5'd9, 1, PW'(128'hDD), 5'd10, 1, 0);
        step(1, PW'(128'hEE), 5'd11, 0, '0, '0, 0, 0);
        #3;
        reset = 1;
        FmaValid = 0; DivValid = 0; PostReady = 0;
        #1;
        modelReset();
        checkRegs();
        checkVal("t6DivReady", PW'(DivReady), PW'(1));
        checkVal("t6FmaReady", PW'(FmaReady), PW'(1));
        #2;
        reset = 0;
        @(posedge clk); #1;
        checkRegs();

        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

endmodule
